sort_input_packer: RTL and testbench

- Upstream neighbour of the bubble-sort pipeline top.
- Accepts a serial byte stream under valid/ready handshake and assembles INPUT_NUM bytes into one packed vector.
- Presents that vector on data_out with a single-cycle cks_out strobe, which drives the sorter's data_in/cks_in directly.
- Supports early frame termination by padding the unfilled slots, and counts emitted frames.

---
 rtl/sort_input_packer_pkg.sv | 20 ++
 rtl/sort_input_packer.sv | 122 ++++++++++++
 tb/tb_sort_input_packer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/sort_input_packer_pkg.sv
// Shared constants for the sort input packer and the bubble-sort pipeline it feeds.
// Holds the byte width, default frame geometry and the packer state encoding.
package sort_input_packer_pkg;

   localparam int BYTE_W = 8;
   localparam int DEF_INPUT_NUM = 8;
   localparam logic [BYTE_W-1:0] DEF_PAD_VAL = 8'hFF;
   localparam int DEF_CNT_W = 16;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd1;
   localparam logic [1:0] ST_EMIT = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      FILL = ST_FILL,
      EMIT = ST_EMIT
   } pack_state_t;

endpackage

// File: rtl/sort_input_packer.sv
// Assembles a valid/ready byte stream into INPUT_NUM-byte frames for the sorter,
// padding early-terminated frames and strobing each completed frame for one cycle.
module sort_input_packer
   import sort_input_packer_pkg::*;
#(
   parameter int INPUT_NUM = DEF_INPUT_NUM,
   parameter logic [BYTE_W-1:0] PAD_VAL = DEF_PAD_VAL,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [BYTE_W-1:0]           byte_in,
   input  logic                        byte_valid,
   input  logic                        byte_last,
   output logic                        byte_ready,
   output logic [BYTE_W*INPUT_NUM-1:0] data_out,
   output logic                        cks_out,
   output logic                        short_frame,
   output logic [CNT_W-1:0]            frame_cnt
);

   localparam int VEC_W = BYTE_W * INPUT_NUM;
   localparam int IDX_W = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_NUM - 1);

   pack_state_t       state;
   logic [IDX_W-1:0]  idx;
   logic [VEC_W-1:0]  asm_vec;

   logic              accept;
   logic              at_end;
   logic              done;
   logic              pad_tail;
   logic [VEC_W-1:0]  nxt_vec;

   // Writes byte b into the given slot; when pad is set every later slot becomes PAD_VAL.
   function automatic logic [VEC_W-1:0] pack_slot(
      input logic [VEC_W-1:0]  vec,
      input logic [IDX_W-1:0]  slot,
      input logic [BYTE_W-1:0] b,
      input logic              pad
   );
      logic [VEC_W-1:0] r;
      r = vec;
      for (int k = 0; k < INPUT_NUM; k++) begin
         if (k == int'(slot)) begin
            r[k*BYTE_W +: BYTE_W] = b;
         end else if (pad && (k > int'(slot))) begin
            r[k*BYTE_W +: BYTE_W] = PAD_VAL;
         end else begin
            r[k*BYTE_W +: BYTE_W] = vec[k*BYTE_W +: BYTE_W];
         end
      end
      return r;
   endfunction

   // Handshake decode and next assembled vector including the incoming byte.
   always_comb begin
      accept   = byte_valid && byte_ready;
      at_end   = (idx == LAST_IDX);
      done     = accept && (byte_last || at_end);
      pad_tail = byte_last && !at_end;
      nxt_vec  = pack_slot(asm_vec, idx, byte_in, pad_tail);
   end

   // Frame assembly FSM with registered strobe, ready and counter outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         idx         <= '0;
         asm_vec     <= '0;
         data_out    <= '0;
         cks_out     <= 1'b0;
         short_frame <= 1'b0;
         frame_cnt   <= '0;
         byte_ready  <= 1'b0;
      end else begin
         case (state)
            IDLE, FILL: begin
               if (done) begin
                  data_out    <= nxt_vec;
                  cks_out     <= 1'b1;
                  short_frame <= pad_tail;
                  frame_cnt   <= frame_cnt + CNT_W'(1);
                  byte_ready  <= 1'b0;
                  asm_vec     <= '0;
                  idx         <= '0;
                  state       <= EMIT;
               end else if (accept) begin
                  asm_vec     <= nxt_vec;
                  idx         <= idx + IDX_W'(1);
                  cks_out     <= 1'b0;
                  short_frame <= 1'b0;
                  byte_ready  <= 1'b1;
                  state       <= FILL;
               end else begin
                  cks_out     <= 1'b0;
                  short_frame <= 1'b0;
                  byte_ready  <= 1'b1;
               end
            end
            EMIT: begin
               cks_out     <= 1'b0;
               short_frame <= 1'b0;
               byte_ready  <= 1'b1;
               asm_vec     <= '0;
               idx         <= '0;
               state       <= IDLE;
            end
            default: begin
               cks_out     <= 1'b0;
               short_frame <= 1'b0;
               byte_ready  <= 1'b0;
               asm_vec     <= '0;
               idx         <= '0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sort_input_packer.sv
// Directed bench for sort_input_packer: full, short, back-to-back, stalled,
// mid-frame reset and counter-wrap frames with hand-computed expectations.
module tb_sort_input_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  byte_in = 8'h00;
   logic        byte_valid = 1'b0;
   logic        byte_last = 1'b0;
   logic        byte_ready;
   logic [63:0] data_out;
   logic        cks_out;
   logic        short_frame;
   logic [15:0] frame_cnt;

   logic        w_ready;
   logic [63:0] w_data;
   logic        w_cks;
   logic        w_short;
   logic [1:0]  w_cnt;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int strobes = 0;
   int consec = 0;
   int ready_viol = 0;
   bit prev_cks = 1'b0;
   bit ready_armed = 1'b0;
   int strobe_cyc[$];

   sort_input_packer #(.INPUT_NUM(8), .PAD_VAL(8'hFF), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_last(byte_last), .byte_ready(byte_ready), .data_out(data_out),
      .cks_out(cks_out), .short_frame(short_frame), .frame_cnt(frame_cnt)
   );

   sort_input_packer #(.INPUT_NUM(8), .PAD_VAL(8'hFF), .CNT_W(2)) u_wrap (
      .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
      .byte_last(byte_last), .byte_ready(w_ready), .data_out(w_data),
      .cks_out(w_cks), .short_frame(w_short), .frame_cnt(w_cnt)
   );

   always #5 clk = ~clk;

   // Strobe log, consecutive-strobe and ready/strobe exclusivity monitor.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         if (cks_out) begin
            strobes <= strobes + 1;
            strobe_cyc.push_back(cyc);
         end
         if (cks_out && prev_cks) consec <= consec + 1;
         if (ready_armed && (byte_ready == cks_out)) ready_viol <= ready_viol + 1;
         prev_cks <= cks_out;
      end else begin
         prev_cks <= 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic last);
      int n;
      n = 0;
      byte_valid = 1'b1;
      byte_in    = b;
      byte_last  = last;
      while (!byte_ready && n < 16) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", 64'(n < 16), 64'd1);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      byte_valid = 1'b0;
      byte_last  = 1'b0;
      byte_in    = 8'h00;
   endtask

   task automatic do_reset();
      idle();
      ready_armed = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ready_armed = 1'b1;
   endtask

   task automatic send_frame(input logic [63:0] v, input logic last_on_end);
      for (int i = 0; i < 8; i++) send(v[i*8 +: 8], (i == 7) ? last_on_end : 1'b0);
   endtask

   initial begin
      logic [63:0] full_v;
      logic [63:0] f1, f2, f3;
      logic [1:0]  wrap_exp [5];
      int base;
      int s0;

      full_v = 64'h04_06_02_08_01_07_03_05;
      f1 = 64'h18_17_16_15_14_13_12_11;
      f2 = 64'h28_27_26_25_24_23_22_21;
      f3 = 64'h38_37_36_35_34_33_32_31;
      wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
      wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

      rst = 1'b0;
      @(negedge clk);
      chk("rst_data", data_out, 64'd0);
      chk("rst_cks", 64'(cks_out), 64'd0);
      chk("rst_short", 64'(short_frame), 64'd0);
      chk("rst_cnt", 64'(frame_cnt), 64'd0);
      chk("rst_ready", 64'(byte_ready), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ready_armed = 1'b1;
      chk("ready_after_rst", 64'(byte_ready), 64'd1);

      // Full frame
      send_frame(full_v, 1'b0);
      idle();
      chk("full_cks", 64'(cks_out), 64'd1);
      chk("full_data", data_out, full_v);
      chk("full_short", 64'(short_frame), 64'd0);
      chk("full_cnt", 64'(frame_cnt), 64'd1);
      chk("full_ready_low", 64'(byte_ready), 64'd0);
      @(negedge clk);
      chk("full_cks_drop", 64'(cks_out), 64'd0);
      chk("full_ready_back", 64'(byte_ready), 64'd1);
      chk("full_data_hold", data_out, full_v);

      // Short frame
      send(8'h10, 1'b0);
      send(8'h20, 1'b0);
      send(8'h30, 1'b1);
      idle();
      chk("short_cks", 64'(cks_out), 64'd1);
      chk("short_data", data_out, 64'hFF_FF_FF_FF_FF_30_20_10);
      chk("short_flag", 64'(short_frame), 64'd1);
      chk("short_cnt", 64'(frame_cnt), 64'd2);
      @(negedge clk);
      chk("short_flag_drop", 64'(short_frame), 64'd0);

      // Back-to-back, last on slot 7 of the third frame
      do_reset();
      base = strobe_cyc.size();
      send_frame(f1, 1'b0);
      chk("b2b_f1", data_out, f1);
      send_frame(f2, 1'b0);
      chk("b2b_f2", data_out, f2);
      send_frame(f3, 1'b1);
      idle();
      chk("b2b_f3", data_out, f3);
      chk("b2b_f3_short", 64'(short_frame), 64'd0);
      chk("b2b_cnt", 64'(frame_cnt), 64'd3);
      @(negedge clk);
      chk("b2b_nstrobe", 64'(strobe_cyc.size() - base), 64'd3);
      if (strobe_cyc.size() >= base + 3) begin
         chk("b2b_gap1", 64'(strobe_cyc[base+1] - strobe_cyc[base]), 64'd9);
         chk("b2b_gap2", 64'(strobe_cyc[base+2] - strobe_cyc[base+1]), 64'd9);
      end

      // Stalled full frame
      s0 = strobes;
      for (int i = 0; i < 8; i++) begin
         send(full_v[i*8 +: 8], 1'b0);
         if (i < 7) begin
            idle();
            repeat ($urandom_range(1, 5)) @(negedge clk);
         end
      end
      idle();
      chk("stall_data", data_out, full_v);
      chk("stall_cnt", 64'(frame_cnt), 64'd4);
      repeat (3) @(negedge clk);
      chk("stall_nstrobe", 64'(strobes - s0), 64'd1);

      // Mid-frame reset
      for (int i = 0; i < 4; i++) send(8'hA1 + 8'(i), 1'b0);
      idle();
      s0 = strobes;
      #2;
      ready_armed = 1'b0;
      rst = 1'b0;
      #1;
      chk("mrst_data", data_out, 64'd0);
      chk("mrst_cks", 64'(cks_out), 64'd0);
      chk("mrst_ready", 64'(byte_ready), 64'd0);
      chk("mrst_cnt", 64'(frame_cnt), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ready_armed = 1'b1;
      chk("mrst_nostrobe", 64'(strobes - s0), 64'd0);
      send_frame(full_v, 1'b0);
      idle();
      chk("mrst_data_next", data_out, full_v);
      chk("mrst_cnt_next", 64'(frame_cnt), 64'd1);

      // Counter wrap on the CNT_W=2 instance using single-byte frames
      do_reset();
      for (int f = 0; f < 5; f++) begin
         send(8'h40 + 8'(f), 1'b1);
         idle();
         chk("wrap_cnt", 64'(w_cnt), 64'(wrap_exp[f]));
         if (f == 0) begin
            chk("single_data", w_data, 64'hFF_FF_FF_FF_FF_FF_FF_40);
            chk("single_short", 64'(w_short), 64'd1);
         end
      end
      @(negedge clk);

      chk("no_consec_cks", 64'(consec), 64'd0);
      chk("ready_vs_cks", 64'(ready_viol), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
